// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } muldiv_state_t;

  localparam logic [6:0]  OPCODE_OP     = 7'b0110011;
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
  localparam int unsigned MULDIV_ITERS  = 32;

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider sharing one 64-bit accumulator,
// with operand sign handling, divide special cases and final sign fix-up.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        finish_i,
  input  muldiv_op_t  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        special_o,
  output logic [31:0] result_o
);

  muldiv_op_t  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;

  logic        neg_a, neg_b, div_zero, div_ovf;
  logic [31:0] abs_a, abs_b;

  always_comb begin
    neg_a     = (op_i inside {OpMulh, OpMulhsu, OpDiv, OpRem}) && a_i[31];
    neg_b     = (op_i inside {OpMulh, OpDiv, OpRem}) && b_i[31];
    abs_a     = neg_a ? (~a_i + 32'd1) : a_i;
    abs_b     = neg_b ? (~b_i + 32'd1) : b_i;
    div_zero  = op_i[2] && (b_i == 32'd0);
    div_ovf   = (op_i inside {OpDiv, OpRem}) && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    special_o = div_zero || div_ovf;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {remainder, dividend bits shifting into quotient bits}.
  logic [32:0] mul_sum, div_diff;
  logic [63:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_diff = acc_q[63:31] - {1'b0, opnd_q};
    if (op_q[2]) begin
      acc_step = div_diff[32] ? {acc_q[62:0], 1'b0} : {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
    end
  end

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, final_res;

  always_comb begin
    prod_fix = neg_res_q ? (~acc_step + 64'd1) : acc_step;
    quo_fix  = neg_res_q ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
    rem_fix  = neg_rem_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
    unique case (op_q)
      OpMul:                      final_res = prod_fix[31:0];
      OpMulh, OpMulhsu, OpMulhu:  final_res = prod_fix[63:32];
      OpDiv, OpDivu:              final_res = quo_fix;
      OpRem, OpRemu:              final_res = rem_fix;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (load_i) begin
      op_d      = op_i;
      acc_d     = {32'd0, op_i[2] ? abs_a : abs_b};
      opnd_d    = op_i[2] ? abs_b : abs_a;
      neg_res_d = neg_a ^ neg_b;
      neg_rem_d = neg_a;
      if (div_zero) begin
        result_d = op_i[1] ? a_i : 32'hFFFF_FFFF;
      end else if (div_ovf) begin
        result_d = op_i[1] ? 32'd0 : 32'h8000_0000;
      end else begin
        result_d = 32'd0;
      end
    end else if (step_i) begin
      acc_d = acc_step;
      if (finish_i) begin
        result_d = final_res;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      op_q      <= OpMul;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide functional unit: accepts a reservation-station issue, iterates
// one bit per cycle, then pulses resp and broadcasts the result on its CDB slot.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         comp_issue,
  input  logic [31:0]                  instr_in,
  input  logic [$clog2(ROB_DEPTH)-1:0] tag_dest_in,
  input  logic [31:0]                  data_A_in,
  input  logic [31:0]                  data_B_in,
  output logic                         resp,
  output logic                         busy,
  output logic                         cdb_valid,
  output logic [$clog2(ROB_DEPTH)-1:0] cdb_tag,
  output logic [31:0]                  cdb_data
);

  localparam int unsigned CntW     = $clog2(MULDIV_ITERS);
  localparam logic [CntW-1:0] LastIter = CntW'(MULDIV_ITERS - 1);
  localparam int unsigned TagW     = $clog2(ROB_DEPTH);

  muldiv_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TagW-1:0] tag_q, tag_d;

  logic        load, step, finish, special;
  logic [31:0] result;

  // Only funct3 steers the unit; the remaining fields are decoded upstream.
  logic unused_instr;
  assign unused_instr = ^{instr_in[24:15], instr_in[11:7]} ^
                        (instr_in[6:0] != OPCODE_OP) ^ (instr_in[31:25] != FUNCT7_MULDIV);

  muldiv_datapath u_datapath (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (flush),
    .load_i    (load),
    .step_i    (step),
    .finish_i  (finish),
    .op_i      (muldiv_op_t'(instr_in[14:12])),
    .a_i       (data_A_in),
    .b_i       (data_B_in),
    .special_o (special),
    .result_o  (result)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (comp_issue) begin
          load    = 1'b1;
          tag_d   = tag_dest_in;
          cnt_d   = '0;
          state_d = special ? StDone : StBusy;
        end
      end
      StBusy: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          finish  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    resp      = (state_q == StDone);
    cdb_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    cdb_tag   = (state_q == StDone) ? tag_q : '0;
    cdb_data  = (state_q == StDone) ? result : 32'd0;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide functional unit directly downstream of a reservation station.
- Consumes the station's issue bundle (comp_issue, instr, dest tag, operands A/B) and holds it until done.
- Returns resp to release the station entry, and broadcasts the result for one cycle on its dedicated CDB slot.
- Radix-2: one shift-add (multiply) or restoring-subtract (divide) step per cycle.

Parameters:
ROB_DEPTH, 4, ROB entries; tag width = $clog2(ROB_DEPTH)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous active-low reset (rst==0 resets)
flush  input  1  pipeline flush, synchronous, active-high
comp_issue  input  1  RS has a ready instruction on its outputs; held high until resp
instr_in  input  32  instruction; funct3 = instr_in[14:12] selects op
tag_dest_in  input  $clog2(ROB_DEPTH)  destination ROB tag
data_A_in  input  32  rs1 value
data_B_in  input  32  rs2 value
resp  output  1  one-cycle pulse; operation complete, RS may free entry
busy  output  1  unit holds an accepted operation (BUSY or DONE)
cdb_valid  output  1  CDB slot valid, one cycle, coincident with resp
cdb_tag  output  $clog2(ROB_DEPTH)  ROB tag of result
cdb_data  output  32  result

Behaviour:
- Reset (rst==0) or flush: state IDLE; iteration counter 0; operand/result registers 0; resp=0, busy=0, cdb_valid=0, cdb_tag=0, cdb_data=0. Flush aborts any in-flight op with no broadcast. Reset has priority over flush.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On comp_issue=1, latch funct3, tag, A, B. Compute operand signs: MULH signs A,B; MULHSU signs A only; DIV/REM signs both; unsigned ops sign neither. Latch absolute values and result-sign flags. Counter=0.
  - Next state: DONE if special-case divide, else BUSY.
  - If comp_issue=0, stay in IDLE.
- BUSY:
  - One step per cycle; counter increments.
  - Multiply: 64-bit product accumulator, shift-add over 32 bits of |B|.
  - Divide: restoring, 32 steps on |A|/|B|, 32-bit remainder.
  - When counter==31, fix up signs (negate product, quotient and/or remainder as required), register the result, go to DONE.
  - comp_issue and inputs ignored while BUSY.
- DONE:
  - resp=1, cdb_valid=1, cdb_tag=latched tag, cdb_data=result, for exactly one cycle.
  - Next state IDLE unconditionally.
  - Outputs driven from registers; no combinational input-to-output path.
- Latency: acceptance edge at cycle 0 → BUSY for cycles 1..32 → DONE/resp at cycle 33. Special cases reach DONE at cycle 1.
- Result select:
  - MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32].
  - DIV/DIVU = quotient; REM/REMU = remainder.
  - Remainder takes the sign of the dividend.
- Special cases, with no iteration:
  - Divide by zero: quotient=32'hFFFF_FFFF, remainder=A.
  - Signed overflow (A=32'h8000_0000, B=32'hFFFF_FFFF, DIV/REM): quotient=32'h8000_0000, remainder=0.
- Re-issue: the RS deasserts comp_issue the cycle after resp, so the unit is in IDLE with comp_issue=0 and no double accept occurs. If comp_issue is high in IDLE, it is a new instruction.
- Non-M opcodes: never routed here; behaviour undefined, funct3 still decoded.
- Width rules: all arithmetic in 33/64-bit internal widths; no truncation until result select.

Decomposition:
- Package muldiv_pkg:
  - muldiv_op_t enum on funct3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - muldiv_state_t {IDLE, BUSY, DONE}.
  - Constants OPCODE_OP=7'b0110011, FUNCT7_MULDIV=7'b0000001, MULDIV_ITERS=32.
- Natural sub-module: muldiv_datapath. It holds the accumulator, remainder and quotient registers, the step logic and the sign fix-up. It is driven by FSM strobes (load, step, finish) from muldiv_unit, which keeps the FSM and handshake.

Test Plan:
- MUL, A=7, B=-3 (32'hFFFF_FFFD), tag=2 → resp and cdb_valid high exactly at cycle 33, cdb_tag=2, cdb_data=32'hFFFF_FFEB; low all other cycles.
- MULHU, A=B=32'hFFFF_FFFF → cdb_data=32'hFFFF_FFFE. Same operands with MULH → cdb_data=0.
- DIV, A=-20, B=6 → cdb_data=-3 (32'hFFFF_FFFD). REM with same operands → 32'hFFFF_FFFE (-2). DIVU, A=100, B=7 → 14.
- DIVU, B=0, A=5 → cdb_data=32'hFFFF_FFFF at cycle 1. REM, A=32'h8000_0000, B=-1 → cdb_data=0 at cycle 1.
- Flush at cycle 10 of a DIV → no cdb_valid or resp ever for that tag; busy=0 next cycle; a new MUL issued next accepts normally.
- comp_issue held high through BUSY, dropping the cycle after resp, then re-asserted with a new tag → exactly one broadcast per instruction. rst=0 mid-BUSY → all outputs 0 next cycle.
